smg_scan: RTL and testbench

Multiplexed 4-digit seven-segment display scanner. It consumes the 16-bit display word produced by `smg_data` and shows it on the board's common-anode display as four hex digits. Digit 3 shows `data[15:12]` and digit 0 shows `data[3:0]`. A dead-time blank between digits suppresses ghosting. Inputs are latched once per frame, so a digit never mixes old and new values.

---
 rtl/smg_scan_if.sv | 22 ++
 rtl/smg_scan.sv | 160 ++++++++++++++++
 tb/tb_smg_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/smg_scan_if.sv
// Signal bundle between the display-word source and the seven-segment scanner.
interface smg_scan_if;
  logic [15:0] data;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  // Source side: supplies the display word, observes the panel drive.
  modport master (
    output data, dp_en, blank_lz,
    input  an, seg, dp, frame_done
  );

  // Scanner side: consumes the display word, drives the panel.
  modport slave (
    input  data, dp_en, blank_lz,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/smg_scan.sv
// Multiplexed 4-digit common-anode seven-segment scanner with dead-time
// blanking, per-frame input shadowing and optional leading-zero blanking.
module smg_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk_100Mhz,
  input  logic       rst,
  smg_scan_if.slave  bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more significant nibble are 0;
  // digit 0 always shows so a zero word still reads "0".
  function automatic logic is_leading_zero(input logic [15:0] d, input logic [1:0] k);
    logic z;
    case (k)
      2'd3:    z = (d[15:12] == 4'h0);
      2'd2:    z = (d[15:8]  == 8'h00);
      2'd1:    z = (d[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sh_data_q, sh_data_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic             sh_lz_q, sh_lz_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic [3:0] on_an;
  logic [6:0] on_seg;
  logic       on_dp;

  // Panel drive for the current digit, computed from the frame's shadow copy.
  always_comb begin
    on_an  = ~(4'b0001 << digit_q);
    on_seg = (sh_lz_q && is_leading_zero(sh_data_q, digit_q))
             ? 7'h7F : seg_decode(sh_data_q[{digit_q, 2'b00} +: 4]);
    on_dp  = ~sh_dp_q[digit_q];
  end

  // Scan sequencing: BLANK dead time, then ON for the digit, then advance.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q + 1'b1;
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_lz_d      = sh_lz_q;
    an_d         = an_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    frame_done_d = 1'b0;

    // Start of a frame: take a coherent snapshot of all inputs.
    if (state_q == ST_BLANK && digit_q == 2'd0 && cnt_q == '0) begin
      sh_data_d = bus.data;
      sh_dp_d   = bus.dp_en;
      sh_lz_d   = bus.blank_lz;
    end

    if (state_q == ST_BLANK) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_ON;
        cnt_d   = '0;
        an_d    = on_an;
        seg_d   = on_seg;
        dp_d    = on_dp;
      end
    end else begin
      an_d  = on_an;
      seg_d = on_seg;
      dp_d  = on_dp;
      if (cnt_q == ON_LAST) begin
        state_d      = ST_BLANK;
        cnt_d        = '0;
        digit_d      = digit_q + 2'd1;
        frame_done_d = (digit_q == 2'd3);
        an_d         = 4'b1111;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
      end
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      sh_data_q    <= 16'h0000;
      sh_dp_q      <= 4'h0;
      sh_lz_q      <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_lz_q      <= sh_lz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_smg_scan.sv
// Self-checking bench for smg_scan: a frame-position model derived from the
// scan schedule predicts every output cycle by cycle.
module tb_smg_scan;

  localparam int SD  = 4;
  localparam int BC  = 2;
  localparam int DPC = SD + BC;
  localparam int FPC = 4 * DPC;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  smg_scan_if ifc ();

  smg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk_100Mhz (clk),
    .rst        (rst),
    .bus        (ifc)
  );

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;
  int n = 0;
  int fd_seen = 0;

  logic [15:0] m_data = 16'h0;
  logic [3:0]  m_dp   = 4'h0;
  logic        m_lz   = 1'b0;

  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fd;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h at edge %0d", tag, obs, exp, n);
    end
  endtask

  // One clock edge: advance the model, then compare outputs 1 ns later.
  task automatic step();
    int p, d, q;
    logic on;
    @(posedge clk);
    if (rst) begin
      n = 0;
      m_data = 16'h0; m_dp = 4'h0; m_lz = 1'b0;
      e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      n++;
      p = (n - 1) % FPC;
      if (p == 0) begin
        m_data = ifc.data; m_dp = ifc.dp_en; m_lz = ifc.blank_lz;
      end
      d  = p / DPC;
      q  = p % DPC;
      on = (q >= BC - 1) && (q <= BC + SD - 2);
      e_fd = (p == FPC - 1);
      if (on) begin
        e_an  = ~(4'b0001 << d);
        e_dp  = ~m_dp[d];
        if (m_lz && d >= 1 && ((m_data >> (4 * d)) == 16'h0))
          e_seg = 7'h7F;
        else
          e_seg = dec_tab[(m_data >> (4 * d)) & 16'hF];
      end else begin
        e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
      end
    end
    #1;
    check_eq("an", {12'h0, ifc.an}, {12'h0, e_an});
    check_eq("seg", {9'h0, ifc.seg}, {9'h0, e_seg});
    check_eq("dp", {15'h0, ifc.dp}, {15'h0, e_dp});
    check_eq("frame_done", {15'h0, ifc.frame_done}, {15'h0, e_fd});
    check_eq("an_onehot", 16'($countones(~ifc.an) <= 1), 16'h1);
    if (ifc.frame_done === 1'b1) fd_seen++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    ifc.data = 16'h1234; ifc.dp_en = 4'h0; ifc.blank_lz = 1'b0;

    // Reset state, then normal scanning of 1234.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * FPC);

    // Change data while digit 1 is ON; frame must stay coherent.
    rst = 1'b1; run(1); rst = 1'b0;
    run(DPC + 2);
    ifc.data = 16'hABCD;
    run(2 * FPC);

    // Leading-zero blanking with decimal point, then an all-zero word.
    ifc.data = 16'h0050; ifc.blank_lz = 1'b1; ifc.dp_en = 4'b0100;
    run(2 * FPC);
    ifc.data = 16'h0000;
    run(2 * FPC);

    // One-cycle reset while digit 2 is ON.
    ifc.blank_lz = 1'b0; ifc.dp_en = 4'h0; ifc.data = 16'h5678;
    rst = 1'b1; run(1); rst = 1'b0;
    run(2 * DPC + 2);
    rst = 1'b1; run(1); rst = 1'b0;
    run(FPC);

    // Decode sweep over all nibble values.
    for (int v = 0; v < 16; v++) begin
      ifc.data = {4{4'(v)}};
      ifc.dp_en = 4'(v);
      run(FPC);
    end

    // Ten-frame soak with random inputs changing at random times.
    rst = 1'b1; run(1); rst = 1'b0;
    fd_seen = 0;
    for (int i = 0; i < 10 * FPC; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ifc.data     = 16'($urandom);
        ifc.dp_en    = 4'($urandom);
        ifc.blank_lz = 1'($urandom);
      end
      step();
    end
    check_eq("frame_count", 16'(fd_seen), 16'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
